// File: rtl/covariance_launcher.sv
// covariance_launcher
//   Upstream call sequencer for the covariance HLS component. Host jobs
//   (data pointer, cov pointer) are queued in a small FIFO, then issued one
//   at a time over the component's start/busy call interface. Each return
//   on the done/stall interface produces one tagged completion record.
//
// Ports
//   clock, resetn            clock, async active-low reset
//   job_valid/ready, job_*   host job offer (ready = queue not full)
//   comp_start/busy          call interface (valid / stall)
//   comp_data, comp_cov      call arguments, held stable while launching
//   comp_done/stall          return interface (valid / stall)
//   cpl_valid/ready          single-entry completion record handshake
//   cpl_tag, cpl_cycles      wrapping job sequence number, call latency
//   idle                     nothing queued, running or pending
//
// Build option
//   COV_LAUNCH_PERF_EN : when defined, a saturating cycle counter measures
//   each call from accept to return and reports it on cpl_cycles; when
//   undefined the counter is omitted and cpl_cycles reads 0.
module covariance_launcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int CYC_W      = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [63:0]      job_data_ptr,
  input  logic [63:0]      job_cov_ptr,
  output logic             comp_start,
  input  logic             comp_busy,
  output logic [63:0]      comp_data,
  output logic [63:0]      comp_cov,
  input  logic             comp_done,
  output logic             comp_stall,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [TAG_W-1:0] cpl_tag,
  output logic [CYC_W-1:0] cpl_cycles,
  output logic             idle
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_e;

  // Reset tree: asserts asynchronously, releases on the first clock edge.
  // Its output also gates job_ready so the host sees ready one cycle after
  // resetn deasserts.
  logic rst_n_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rst_n_q <= 1'b0;
    else         rst_n_q <= 1'b1;
  end

  state_e            state_q, state_d;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [63:0]       fifo_data_q [FIFO_DEPTH];
  logic [63:0]       fifo_cov_q  [FIFO_DEPTH];
  logic [63:0]       comp_data_q, comp_cov_q;
  logic [TAG_W-1:0]  tag_cnt_q, cur_tag_q, cpl_tag_q;
  logic              cpl_valid_q;
  logic              full, empty, push, pop;
  logic              accept_call, accept_ret;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign job_ready = rst_n_q && !full;
  assign push      = job_valid && job_ready;
  assign pop       = (state_q == S_IDLE) && !empty;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q[AW-1:0]] <= job_data_ptr;
      fifo_cov_q[wr_ptr_q[AW-1:0]]  <= job_cov_ptr;
    end
  end

  always_comb begin
    state_d     = state_q;
    comp_start  = 1'b0;
    comp_stall  = 1'b1;
    accept_call = 1'b0;
    accept_ret  = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_LAUNCH;
      S_LAUNCH: begin
        comp_start = 1'b1;
        if (!comp_busy) begin
          accept_call = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        // Only back-pressure the return while an undrained record is held.
        comp_stall = cpl_valid_q && !cpl_ready;
        if (comp_done && !comp_stall) begin
          accept_ret = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      comp_data_q <= '0;
      comp_cov_q  <= '0;
      tag_cnt_q   <= '0;
      cur_tag_q   <= '0;
      cpl_tag_q   <= '0;
      cpl_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        comp_data_q <= fifo_data_q[rd_ptr_q[AW-1:0]];
        comp_cov_q  <= fifo_cov_q[rd_ptr_q[AW-1:0]];
        cur_tag_q   <= tag_cnt_q;
        tag_cnt_q   <= tag_cnt_q + 1'b1;
      end
      // A new return wins over a same-cycle drain, so valid stays high.
      if (accept_ret) begin
        cpl_valid_q <= 1'b1;
        cpl_tag_q   <= cur_tag_q;
      end else if (cpl_valid_q && cpl_ready) begin
        cpl_valid_q <= 1'b0;
      end
    end
  end

`ifdef COV_LAUNCH_PERF_EN
  logic [CYC_W-1:0] cyc_q, cyc_inc, cpl_cycles_q;
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  // Counter is 0 on the first RUN cycle, so a return one cycle after
  // accept reports 1.
  always_ff @(posedge clock or negedge rst_n_q) begin
    if (!rst_n_q) begin
      cyc_q        <= '0;
      cpl_cycles_q <= '0;
    end else begin
      if (accept_call)              cyc_q <= '0;
      else if (state_q == S_RUN)    cyc_q <= cyc_inc;
      if (accept_ret) cpl_cycles_q <= cyc_inc;
    end
  end
  assign cpl_cycles = cpl_cycles_q;
`else
  assign cpl_cycles = '0;
`endif

  assign comp_data = comp_data_q;
  assign comp_cov  = comp_cov_q;
  assign cpl_valid = cpl_valid_q;
  assign cpl_tag   = cpl_tag_q;
  assign idle      = (state_q == S_IDLE) && empty && !cpl_valid_q;

endmodule

// File: tb/tb_covariance_launcher.sv
module tb_covariance_launcher;
  logic        clock = 1'b0;
  logic        resetn;
  logic        job_valid;
  logic        job_ready;
  logic [63:0] job_data_ptr, job_cov_ptr;
  logic        comp_start, comp_busy;
  logic [63:0] comp_data, comp_cov;
  logic        comp_done, comp_stall;
  logic        cpl_valid, cpl_ready;
  logic [3:0]  cpl_tag;
  logic [31:0] cpl_cycles;
  logic        idle;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  covariance_launcher #(.FIFO_DEPTH(4), .TAG_W(4), .CYC_W(32)) dut (
    .clock(clock), .resetn(resetn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_data_ptr(job_data_ptr), .job_cov_ptr(job_cov_ptr),
    .comp_start(comp_start), .comp_busy(comp_busy),
    .comp_data(comp_data), .comp_cov(comp_cov),
    .comp_done(comp_done), .comp_stall(comp_stall),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_tag(cpl_tag), .cpl_cycles(cpl_cycles), .idle(idle)
  );

  typedef struct {
    logic [63:0] data;
    logic [63:0] cov;
    int          busy;
    int          dly;
    logic [3:0]  tag;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cyc(input logic [31:0] c);
`ifdef COV_LAUNCH_PERF_EN
    return c;
`else
    return 32'd0;
`endif
  endfunction

  // Offer one job; returns at the negedge after it was pushed.
  task automatic push_job(input logic [63:0] d, input logic [63:0] c);
    int n = 0;
    job_valid = 1'b1; job_data_ptr = d; job_cov_ptr = c;
    while (!job_ready && n < 20) begin @(negedge clock); n++; end
    chk("push_ready", job_ready, 1'b1);
    @(negedge clock);
    job_valid = 1'b0;
  endtask

  // Serve one call: busy for busy_n launch cycles, return dly cycles after
  // accept, then check the completion record.
  task automatic run_job(input int busy_n, input int dly, input logic [63:0] d,
                         input logic [63:0] c, input logic [3:0] tag,
                         input logic [31:0] cyc);
    int n = 0;
    while (!comp_start && n < 50) begin @(negedge clock); n++; end
    chk("start_seen", comp_start, 1'b1);
    chk("launch_stall", comp_stall, 1'b1);
    for (int k = 0; k <= busy_n; k++) begin
      comp_busy = (k < busy_n);
      chk("launch_start", comp_start, 1'b1);
      chk("launch_data", comp_data, d);
      chk("launch_cov", comp_cov, c);
      @(negedge clock);
    end
    comp_busy = 1'b0;
    chk("run_start_low", comp_start, 1'b0);
    chk("run_stall_low", comp_stall, 1'b0);
    repeat (dly - 1) @(negedge clock);
    comp_done = 1'b1;
    @(negedge clock);
    comp_done = 1'b0;
    chk("cpl_valid", cpl_valid, 1'b1);
    chk("cpl_tag", cpl_tag, tag);
    chk("cpl_cycles", cpl_cycles, exp_cyc(cyc));
    chk("ret_start_low", comp_start, 1'b0);
  endtask

  initial begin
    tbl[0] = '{64'h1000, 64'h2000, 0, 5, 4'd0, 32'd5};
    tbl[1] = '{64'h0000_0000_0000_3040, 64'h0000_0000_0000_5080, 3, 1, 4'd1, 32'd1};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, 2, 4'd2, 32'd2};
    tbl[3] = '{64'hDEAD_BEEF_0000_0040, 64'h1234_5678_9ABC_DEF0, 0, 7, 4'd3, 32'd7};

    resetn = 1'b0; job_valid = 1'b0; job_data_ptr = '0; job_cov_ptr = '0;
    comp_busy = 1'b0; comp_done = 1'b0; cpl_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_job_ready", job_ready, 1'b0);
    chk("rst_start", comp_start, 1'b0);
    chk("rst_stall", comp_stall, 1'b1);
    chk("rst_cpl_valid", cpl_valid, 1'b0);
    chk("rst_data", comp_data, 64'h0);
    chk("rst_cov", comp_cov, 64'h0);
    chk("rst_tag", cpl_tag, 4'h0);
    chk("rst_cycles", cpl_cycles, 32'h0);
    chk("rst_idle", idle, 1'b1);
    resetn = 1'b1;
    #1 chk("rel_ready_low", job_ready, 1'b0);
    @(negedge clock);
    chk("rel_ready_high", job_ready, 1'b1);

    // Single jobs from the table
    for (int i = 0; i < 4; i++) begin
      push_job(tbl[i].data, tbl[i].cov);
      run_job(tbl[i].busy, tbl[i].dly, tbl[i].data, tbl[i].cov, tbl[i].tag, tbl[i].cyc);
      @(negedge clock);
      chk("drained", cpl_valid, 1'b0);
      chk("idle_again", idle, 1'b1);
    end

    // Five jobs back-to-back; first launch held busy so the queue fills
    comp_busy = 1'b1;
    for (int j = 0; j < 5; j++)
      push_job(64'h1_0000 + 64'(j) * 64'h100, 64'h2_0000 + 64'(j) * 64'h100);
    chk("q_full_ready", job_ready, 1'b0);
    for (int j = 0; j < 5; j++) begin
      run_job(1, 3, 64'h1_0000 + 64'(j) * 64'h100, 64'h2_0000 + 64'(j) * 64'h100,
              4'(4 + j), 32'd3);
      if (j < 4) begin
        chk("b2b_gap_idle", comp_start, 1'b0);
        @(negedge clock);
        chk("b2b_gap_start", comp_start, 1'b1);
        if (j == 0) chk("q_ready_after_pop", job_ready, 1'b1);
      end
    end
    @(negedge clock);

    // Completion backpressure
    cpl_ready = 1'b0;
    push_job(64'hA000, 64'hA100);
    push_job(64'hB000, 64'hB100);
    run_job(0, 2, 64'hA000, 64'hA100, 4'd9, 32'd2);
    begin
      int n = 0;
      while (!comp_start && n < 20) begin @(negedge clock); n++; end
    end
    chk("bp_start", comp_start, 1'b1);
    chk("bp_data", comp_data, 64'hB000);
    @(negedge clock);
    comp_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("bp_stall", comp_stall, 1'b1);
      chk("bp_hold_valid", cpl_valid, 1'b1);
      chk("bp_hold_tag", cpl_tag, 4'd9);
    end
    cpl_ready = 1'b1;
    #1 chk("bp_stall_release", comp_stall, 1'b0);
    @(negedge clock);
    comp_done = 1'b0;
    chk("bp_valid_kept", cpl_valid, 1'b1);
    chk("bp_new_tag", cpl_tag, 4'd10);
    chk("bp_new_cycles", cpl_cycles, exp_cyc(32'd4));
    @(negedge clock);
    chk("bp_drained", cpl_valid, 1'b0);

    // Tag wrap: jobs 11..16, the 17th carries tag 0
    for (int j = 11; j < 17; j++) begin
      push_job(64'h4000 + 64'(j), 64'h8000 + 64'(j));
      run_job(0, 1, 64'h4000 + 64'(j), 64'h8000 + 64'(j), 4'(j), 32'd1);
    end
    chk("tag_wrap", cpl_tag, 4'd0);
    @(negedge clock);

    // Reset during RUN with two jobs queued
    push_job(64'hC000, 64'hC100);
    push_job(64'hC200, 64'hC300);
    push_job(64'hC400, 64'hC500);
    chk("mid_run_data", comp_data, 64'hC000);
    chk("mid_run_stall", comp_stall, 1'b0);
    resetn = 1'b0;
    #1;
    chk("mr_job_ready", job_ready, 1'b0);
    chk("mr_start", comp_start, 1'b0);
    chk("mr_stall", comp_stall, 1'b1);
    chk("mr_cpl_valid", cpl_valid, 1'b0);
    chk("mr_data", comp_data, 64'h0);
    chk("mr_idle", idle, 1'b1);
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("mr_q_empty", idle, 1'b1);
    chk("mr_no_cpl", cpl_valid, 1'b0);
    chk("mr_no_start", comp_start, 1'b0);
    push_job(64'hD000, 64'hD100);
    run_job(0, 3, 64'hD000, 64'hD100, 4'd0, 32'd3);
    @(negedge clock);
    chk("final_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/covariance_launcher.md
Name: covariance_launcher

Overview:
- Upstream call sequencer for the covariance HLS component.
- Queues host jobs, each a (data pointer, cov pointer) pair, then drives the component's start/busy call interface one job at a time.
- Consumes the done/stall return interface and emits one tagged completion record per job.
- Sits between the host/CSR job source and the covariance component; it never touches the component's Avalon-MM master.

Parameters:
- FIFO_DEPTH, 4, job queue entries (power of 2, >=2)
- TAG_W, 4, completion tag width; the tag is a wrapping job sequence number
- CYC_W, 32, cycle-count field width

Ports:
- clock  in  1  single clock
- resetn  in  1  asynchronous active-low reset
- job_valid  in  1  host job offer
- job_ready  out  1  job queue not full
- job_data_ptr  in  64  byte address of the data matrix
- job_cov_ptr  in  64  byte address of the cov matrix
- comp_start  out  1  to component call.valid
- comp_busy  in  1  from component call.stall
- comp_data  out  64  to component data argument
- comp_cov  out  64  to component cov argument
- comp_done  in  1  from component return.valid
- comp_stall  out  1  to component return.stall
- cpl_valid  out  1  completion record valid
- cpl_ready  in  1  completion consumer ready
- cpl_tag  out  TAG_W  tag of the completed job
- cpl_cycles  out  CYC_W  latency of the call, accept to return
- idle  out  1  queue empty, FSM in IDLE, no completion pending

Behaviour:
- Reset (async assert, synchronous deassert inside the design's reset tree):
  - job_ready=0, comp_start=0, comp_stall=1, cpl_valid=0.
  - comp_data, comp_cov, cpl_tag, cpl_cycles all 0; idle=1; tag counter=0.
  - FIFO emptied.
  - job_ready rises 1 cycle after deassert.
- Job queue:
  - Push on job_valid&&job_ready; job_ready=!full.
  - No push when full, even if a pop happens the same cycle.
  - A push into an empty queue is visible to the FSM the next cycle. Pointers are stored unmodified.
- FSM states: IDLE, LAUNCH, RUN. At most one call outstanding.
- IDLE:
  - If the queue is non-empty: pop the head into the argument registers (comp_data, comp_cov) and latch cur_tag=tag counter.
  - Increment the tag counter (wraps at 2^TAG_W) and go to LAUNCH.
  - comp_start=0, comp_stall=1.
- LAUNCH:
  - comp_start=1; arguments held stable.
  - The call is accepted on the cycle comp_start&&!comp_busy; then clear the cycle counter to 0 and go to RUN.
  - comp_busy high holds LAUNCH indefinitely.
  - comp_stall=1, so a stray comp_done is not consumed.
- RUN:
  - comp_start=0; the cycle counter increments each cycle (saturates at all-ones).
  - comp_stall = cpl_valid&&!cpl_ready.
  - The return is accepted on comp_done&&!comp_stall. On that cycle:
    - capture cpl_tag=cur_tag and cpl_cycles=counter+1;
    - set cpl_valid and go to IDLE.
  - A return in the cycle right after accept reports cpl_cycles=1.
- Completion register (single entry):
  - Cleared on cpl_valid&&cpl_ready.
  - A simultaneous drain and new return is legal: the new record overwrites and cpl_valid stays 1.
- Back-to-back jobs: the minimum gap is return accept -> IDLE pop -> LAUNCH start, i.e. 2 cycles between a return accept and the next comp_start.
- idle = (state==IDLE)&&empty&&!cpl_valid.
- Reset mid-operation: the job and completion are discarded. The component shares resetn, so no call is left dangling.

Optional Feature:
- COV_LAUNCH_PERF_EN
- Defined: the cycle counter and cpl_cycles behave as above.
- Undefined: counter logic is omitted and cpl_cycles is tied to 0; all other behaviour is unchanged.

Test Plan:
- Single job (data=0x1000, cov=0x2000), comp_busy=0, comp_done 5 cycles after accept, cpl_ready=1 -> one comp_start pulse with comp_data=0x1000, comp_cov=0x2000; cpl_tag=0, cpl_cycles=5 (0 without the macro); idle returns to 1.
- comp_busy held high 3 cycles during LAUNCH -> comp_start stays high 4 cycles with stable arguments; counter starts only after accept.
- 5 jobs pushed back-to-back with FIFO_DEPTH=4 -> job_ready drops after 4 are queued (first already popped: 5th accepted once head pops). Completions carry tags 0..4 in order; start pulses are spaced >=2 cycles after each return accept.
- Completion backpressure: cpl_ready=0 holding job 0's record while job 1 asserts comp_done -> comp_stall=1 until cpl_ready rises. Job 1's return is accepted the same cycle job 0's record drains; cpl_valid never drops.
- Tag wrap with TAG_W=4: 17 jobs -> the 17th completion has cpl_tag=0.
- resetn pulsed low during RUN with 2 jobs queued -> outputs at reset values immediately, queue empty, tag 0 on the next job, no spurious cpl_valid.
